pipeline_hazard_sequencer: RTL and testbench

- Central stall/flush controller for the 5-stage pipeline.
- Drives the enable and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus the PC write enable.
- Sequences four conditions:
  - instruction-fetch wait
  - data-memory wait
  - load-use bubbles
  - branch/jump redirects and halt drain
- Sits beside the datapath. Inputs are taken from pipeline register outputs and the cache hit lines.

---
 rtl/pipeline_hazard_sequencer_if.sv | 43 ++++
 rtl/pipeline_hazard_sequencer.sv | 129 ++++++++++++
 tb/tb_pipeline_hazard_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_sequencer_if.sv
// Hazard-control bundle between the 5-stage datapath and pipeline_hazard_sequencer.
// master = datapath side (drives hit/hazard info), slave = sequencer side (drives enables/flushes).
interface pipeline_hazard_sequencer_if #(
  parameter int REG_W = 5
);
  logic             ihit;
  logic             dhit;
  logic [REG_W-1:0] dec_rs;
  logic [REG_W-1:0] dec_rt;
  logic             dec_uses_rt;
  logic             dec_jump;
  logic             ID_dread;
  logic [REG_W-1:0] ID_rt;
  logic             EX_dread;
  logic             EX_dwrite;
  logic             EX_halt;
  logic             mem_redirect;
  logic             MEM_halt;
  logic             pc_en;
  logic             IF_EN;
  logic             ID_EN;
  logic             EX_EN;
  logic             MEM_EN;
  logic             IF_FLUSH;
  logic             ID_FLUSH;
  logic             EX_FLUSH;
  logic             MEM_FLUSH;
  logic             halt;

  modport master (
    output ihit, dhit, dec_rs, dec_rt, dec_uses_rt, dec_jump, ID_dread, ID_rt,
           EX_dread, EX_dwrite, EX_halt, mem_redirect, MEM_halt,
    input  pc_en, IF_EN, ID_EN, EX_EN, MEM_EN,
           IF_FLUSH, ID_FLUSH, EX_FLUSH, MEM_FLUSH, halt
  );

  modport slave (
    input  ihit, dhit, dec_rs, dec_rt, dec_uses_rt, dec_jump, ID_dread, ID_rt,
           EX_dread, EX_dwrite, EX_halt, mem_redirect, MEM_halt,
    output pc_en, IF_EN, ID_EN, EX_EN, MEM_EN,
           IF_FLUSH, ID_FLUSH, EX_FLUSH, MEM_FLUSH, halt
  );
endinterface

// File: rtl/pipeline_hazard_sequencer.sv
// Stall/flush sequencer for the 5-stage pipeline: fetch/data waits, load-use bubbles, redirects, halt drain.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_sequencer #(
  parameter int REG_W = 5
) (
  input  logic                      CLK,
  input  logic                      nRST,
  pipeline_hazard_sequencer_if.slave bus
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]               perf_stall_cycles,
  output logic [31:0]               perf_lu_bubbles,
  output logic [31:0]               perf_redirects
`endif
);

  typedef enum logic [1:0] {RUN, DMEM_WAIT, DRAIN, HALTED} state_t;

  localparam logic [REG_W-1:0] REG_ZERO = '0;

  state_t state, state_nxt;
  logic   squash_pend, squash_nxt;
  logic   dmem_busy, lu, ihit_eff;
  logic   pc_en_c, if_en_c, id_en_c, ex_en_c, mem_en_c;
  logic   if_fl_c, id_fl_c, ex_fl_c, mem_fl_c;
  logic   lu_bubble, redir_acc;

  assign dmem_busy = (bus.EX_dread | bus.EX_dwrite) & ~bus.dhit;
  assign lu = bus.ID_dread & (bus.ID_rt != REG_ZERO) &
              ((bus.ID_rt == bus.dec_rs) | (bus.dec_uses_rt & (bus.ID_rt == bus.dec_rt)));
  // Single-ported memory: a fetch cannot complete while a data access is being waited on.
  assign ihit_eff = bus.ihit & (state != DMEM_WAIT);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= RUN;
      squash_pend <= 1'b0;
    end else begin
      state       <= state_nxt;
      squash_pend <= squash_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    squash_nxt = squash_pend;
    pc_en_c    = 1'b1;
    if_en_c    = 1'b1;
    id_en_c    = 1'b1;
    ex_en_c    = 1'b1;
    mem_en_c   = 1'b1;
    if_fl_c    = 1'b0;
    id_fl_c    = 1'b0;
    ex_fl_c    = 1'b0;
    mem_fl_c   = 1'b0;
    lu_bubble  = 1'b0;
    redir_acc  = 1'b0;
    case (state)
      RUN, DMEM_WAIT: begin
        if (dmem_busy) begin
          // Freeze holds EX/MEM, so a pending redirect is re-evaluated once dhit arrives.
          {pc_en_c, if_en_c, id_en_c, ex_en_c, mem_en_c} = '0;
          state_nxt = DMEM_WAIT;
        end else begin
          state_nxt = RUN;
          if (bus.mem_redirect) begin
            {if_fl_c, id_fl_c, ex_fl_c} = 3'b111;
            redir_acc = 1'b1;
            if (!ihit_eff) squash_nxt = 1'b1;
          end else if (bus.EX_halt) begin
            pc_en_c   = 1'b0;
            if_fl_c   = 1'b1;
            state_nxt = DRAIN;
          end else if (lu) begin
            pc_en_c   = 1'b0;
            if_en_c   = 1'b0;
            id_fl_c   = 1'b1;
            lu_bubble = 1'b1;
          end else if (!ihit_eff || squash_pend) begin
            // A hit while squash_pend is the stale wrong-path fetch: drop it but advance PC to refetch.
            if_fl_c = 1'b1;
            if (!ihit_eff) pc_en_c = 1'b0;
            else           squash_nxt = 1'b0;
          end else if (bus.dec_jump) begin
            if_fl_c = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (dmem_busy) begin
          {pc_en_c, if_en_c, id_en_c, ex_en_c, mem_en_c} = '0;
        end else begin
          pc_en_c = 1'b0;
          if_fl_c = 1'b1;
        end
      end
      default: begin
        {pc_en_c, if_en_c, id_en_c, ex_en_c, mem_en_c} = '0;
      end
    endcase
    if (bus.MEM_halt) state_nxt = HALTED;
  end

  assign bus.pc_en     = pc_en_c;
  assign bus.IF_EN     = if_en_c;
  assign bus.ID_EN     = id_en_c;
  assign bus.EX_EN     = ex_en_c;
  assign bus.MEM_EN    = mem_en_c;
  assign bus.IF_FLUSH  = if_fl_c;
  assign bus.ID_FLUSH  = id_fl_c;
  assign bus.EX_FLUSH  = ex_fl_c;
  assign bus.MEM_FLUSH = mem_fl_c;
  assign bus.halt      = (state == HALTED);

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      perf_stall_cycles <= '0;
      perf_lu_bubbles   <= '0;
      perf_redirects    <= '0;
    end else if (state != HALTED) begin
      if (!pc_en_c) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (lu_bubble) perf_lu_bubbles  <= perf_lu_bubbles + 32'd1;
      if (redir_acc) perf_redirects   <= perf_redirects + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Directed-vector bench for pipeline_hazard_sequencer; control word is
// {pc_en, IF_EN, ID_EN, EX_EN, MEM_EN, IF_FLUSH, ID_FLUSH, EX_FLUSH, MEM_FLUSH, halt}.
module tb_pipeline_hazard_sequencer;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int   checks = 0;
  int   failures = 0;

  pipeline_hazard_sequencer_if #(.REG_W(5)) bus ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cycles, perf_lu_bubbles, perf_redirects;
`endif

  pipeline_hazard_sequencer #(.REG_W(5)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_lu_bubbles   (perf_lu_bubbles),
    .perf_redirects    (perf_redirects)
`endif
  );

  always #5 CLK = ~CLK;

  logic [9:0] ctl;
  assign ctl = {bus.pc_en, bus.IF_EN, bus.ID_EN, bus.EX_EN, bus.MEM_EN,
                bus.IF_FLUSH, bus.ID_FLUSH, bus.EX_FLUSH, bus.MEM_FLUSH, bus.halt};

  localparam logic [9:0] NORMAL  = 10'b1_1111_0000_0;
  localparam logic [9:0] FREEZE  = 10'b0_0000_0000_0;
  localparam logic [9:0] FMISS   = 10'b0_1111_1000_0;
  localparam logic [9:0] REFETCH = 10'b1_1111_1000_0;
  localparam logic [9:0] REDIR   = 10'b1_1111_1110_0;
  localparam logic [9:0] BUBBLE  = 10'b0_0111_0100_0;
  localparam logic [9:0] HALTED  = 10'b0_0000_0000_1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.ihit = 1'b1; bus.dhit = 1'b0; bus.dec_rs = '0; bus.dec_rt = '0;
    bus.dec_uses_rt = 1'b0; bus.dec_jump = 1'b0; bus.ID_dread = 1'b0; bus.ID_rt = '0;
    bus.EX_dread = 1'b0; bus.EX_dwrite = 1'b0; bus.EX_halt = 1'b0;
    bus.mem_redirect = 1'b0; bus.MEM_halt = 1'b0;
  endtask

  initial begin
    idle();
    bus.ihit = 1'b0;
    cyc(); cyc();
    chk("reset_ihit0", 32'(ctl), 32'(FMISS));
    bus.ihit = 1'b1; #1;
    chk("reset_ihit1", 32'(ctl), 32'(NORMAL));
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_reset", perf_stall_cycles | perf_lu_bubbles | perf_redirects, 32'd0);
`endif
    @(negedge CLK); nRST = 1'b1;
    cyc();
    chk("run_normal", 32'(ctl), 32'(NORMAL));

    // load-use on rs
    bus.ID_dread = 1'b1; bus.ID_rt = 5'd5; bus.dec_rs = 5'd5; #1;
    chk("lu_rs", 32'(ctl), 32'(BUBBLE));
    cyc(); bus.ID_dread = 1'b0; #1;
    chk("lu_after", 32'(ctl), 32'(NORMAL));
    bus.ID_dread = 1'b1; bus.ID_rt = 5'd0; bus.dec_rs = 5'd0; #1;
    chk("lu_r0", 32'(ctl), 32'(NORMAL));
    bus.ID_rt = 5'd7; bus.dec_rs = 5'd3; bus.dec_rt = 5'd7; bus.dec_uses_rt = 1'b1; #1;
    chk("lu_rt", 32'(ctl), 32'(BUBBLE));
    bus.dec_uses_rt = 1'b0; #1;
    chk("lu_rt_unused", 32'(ctl), 32'(NORMAL));
    cyc(); idle();

    // data wait: 3 busy cycles then dhit (fetch masked on the dhit cycle)
    bus.EX_dwrite = 1'b1; #1;
    chk("dwait0", 32'(ctl), 32'(FREEZE));
    cyc(); chk("dwait1", 32'(ctl), 32'(FREEZE));
    cyc(); chk("dwait2", 32'(ctl), 32'(FREEZE));
    cyc(); bus.dhit = 1'b1; #1;
    chk("dwait_hit", 32'(ctl), 32'(FMISS));
    cyc(); idle(); #1;
    chk("dwait_back", 32'(ctl), 32'(NORMAL));
    bus.EX_dread = 1'b1; bus.dhit = 1'b1; #1;
    chk("dread_fast", 32'(ctl), 32'(NORMAL));
    cyc(); idle();

    // redirect with fetch outstanding
    bus.ihit = 1'b0; bus.mem_redirect = 1'b1; #1;
    chk("redir_miss", 32'(ctl), 32'(REDIR));
    cyc(); bus.mem_redirect = 1'b0; bus.ihit = 1'b1; #1;
    chk("squash_hit", 32'(ctl), 32'(REFETCH));
    cyc();
    chk("squash_clear", 32'(ctl), 32'(NORMAL));

    // redirect behind a data wait
    bus.mem_redirect = 1'b1; bus.EX_dread = 1'b1; #1;
    chk("redir_busy", 32'(ctl), 32'(FREEZE));
    cyc(); bus.dhit = 1'b1; #1;
    chk("redir_dhit", 32'(ctl), 32'(REDIR));
    cyc(); idle(); #1;
    chk("redir_dhit_squash", 32'(ctl), 32'(REFETCH));
    cyc();
    chk("redir_dhit_clear", 32'(ctl), 32'(NORMAL));

    // redirect beats load-use; hit on redirect cycle leaves no squash
    bus.mem_redirect = 1'b1; bus.ID_dread = 1'b1; bus.ID_rt = 5'd9; bus.dec_rs = 5'd9; #1;
    chk("redir_over_lu", 32'(ctl), 32'(REDIR));
    cyc(); idle(); #1;
    chk("redir_hit_nosquash", 32'(ctl), 32'(NORMAL));
    bus.dec_jump = 1'b1; #1;
    chk("jump", 32'(ctl), 32'(REFETCH));
    cyc(); idle();

    // halt drain
    bus.EX_halt = 1'b1; #1;
    chk("ex_halt", 32'(ctl), 32'(FMISS));
    cyc(); bus.EX_halt = 1'b0; #1;
    chk("drain", 32'(ctl), 32'(FMISS));
    bus.MEM_halt = 1'b1; #1;
    chk("drain_memhalt", 32'(ctl), 32'(FMISS));
    cyc(); bus.MEM_halt = 1'b0; #1;
    chk("halted", 32'(ctl), 32'(HALTED));
    bus.mem_redirect = 1'b1; cyc();
    chk("halted_sticky", 32'(ctl), 32'(HALTED));
    bus.mem_redirect = 1'b0;
    @(negedge CLK); nRST = 1'b0; #1;
    chk("async_reset", 32'(ctl), 32'(NORMAL));
    cyc(); nRST = 1'b1; cyc();
    chk("post_reset", 32'(ctl), 32'(NORMAL));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
